// File: rtl/nes_joypad_ports.sv
// ---------------------------------------------------------------------------
// nes_joypad_ports
//
// NES controller port emulation for one to four ports. Each port presents the
// classic 4021-style serial interface to the CPU. joy_strobe loads an 8-bit
// shift register with the current button state. Each falling edge of that
// port's joy_clock then shifts the register right by one. When a port is
// switched to an external physical pad, the serial data comes straight from
// that pad instead. The latch and clock lines are mirrored out to the pad.
//
// Autofire:
//   A free-running divider toggles a phase bit every C_autofire_div cycles.
//   Buttons with their autofire mask bit set are only seen as pressed while
//   the phase is high.
//
// Change reporting:
//   The raw (non-autofire) button vector is registered and debounced. When
//   it differs from the reported state o_btn, o_btn is updated and o_irq is
//   raised. o_btn then stays frozen until i_irq_ack clears o_irq.
//
// Ports:
//   clock            system clock (single clock domain)
//   reset            synchronous, active-high
//   i_buttons        8*C_ports   pressed buttons per port {right,left,down,
//                                up,start,select,b,a}
//   i_autofire_mask  8*C_ports   per-button autofire enable
//   i_ext_select     C_ports     1 = port served by an external pad
//   joy_strobe       1           CPU latch line
//   joy_clock        C_ports     per-port CPU read clock
//   o_joy_data       C_ports     serial data to the CPU, 1 = pressed
//   ext_joy_data     C_ports     external pad data, active-low
//   ext_joy_latch    1           latch to external pads
//   ext_joy_clock    C_ports     read clocks to external pads
//   o_btn            8*C_ports   debounced reported button state
//   o_irq            1           button-change interrupt
//   i_irq_ack        1           clears o_irq
// ---------------------------------------------------------------------------
module nes_joypad_ports #(
  parameter int C_ports         = 2,
  parameter int C_autofire_div  = 1071000,
  parameter int C_debounce_bits = 20,
  parameter int C_fill_ones     = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [8*C_ports-1:0]   i_buttons,
  input  logic [8*C_ports-1:0]   i_autofire_mask,
  input  logic [C_ports-1:0]     i_ext_select,
  input  logic                   joy_strobe,
  input  logic [C_ports-1:0]     joy_clock,
  output logic [C_ports-1:0]     o_joy_data,
  input  logic [C_ports-1:0]     ext_joy_data,
  output logic                   ext_joy_latch,
  output logic [C_ports-1:0]     ext_joy_clock,
  output logic [8*C_ports-1:0]   o_btn,
  output logic                   o_irq,
  input  logic                   i_irq_ack
);

  // Divider width. C_autofire_div is at least 2, so this is at least 1 bit.
  localparam int AF_W = $clog2(C_autofire_div);
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(C_autofire_div - 1);
  localparam logic [AF_W-1:0] AF_ONE  = AF_W'(1);

  localparam int DB_W = C_debounce_bits;
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

  // This bit enters the top of the shift register after the 8 button bits.
  // A real pad returns 1s here; 0 reproduces older emulator behaviour.
  localparam logic FILL_BIT = (C_fill_ones != 0);

  // -------------------------------------------------------------------------
  // Autofire phase generator
  // -------------------------------------------------------------------------
  logic [AF_W-1:0] af_cnt;
  logic            af_phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AF_LAST) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt   <= af_cnt + AF_ONE;
    end
  end

  // An autofire-masked button only counts as pressed during the high phase.
  // Unmasked buttons pass through unchanged.
  logic [8*C_ports-1:0] effective;
  assign effective = i_buttons & (~i_autofire_mask | {(8*C_ports){af_phase}});

  // -------------------------------------------------------------------------
  // joy_clock history, used for falling-edge detection
  // -------------------------------------------------------------------------
  logic [C_ports-1:0] joy_clock_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      joy_clock_q <= '0;
    end else begin
      joy_clock_q <= joy_clock;
    end
  end

  // -------------------------------------------------------------------------
  // Per-port serial shift registers
  // -------------------------------------------------------------------------
  for (genvar p = 0; p < C_ports; p++) begin : g_port
    logic [7:0] shift_reg;
    logic       fall;

    // A falling edge means: high at the last clock, low now.
    assign fall = joy_clock_q[p] & ~joy_clock[p];

    // The strobe keeps reloading for as long as it is held. This also makes
    // a strobe win over a coincident edge, so no bit is lost.
    always_ff @(posedge clock) begin
      if (reset) begin
        shift_reg <= 8'h00;
      end else if (joy_strobe) begin
        shift_reg <= effective[8*p +: 8];
      end else if (fall) begin
        shift_reg <= {FILL_BIT, shift_reg[7:1]};
      end
    end

    // The internal register keeps running while an external pad is selected.
    // Switching the selection back is therefore seamless and immediate.
    assign o_joy_data[p] = i_ext_select[p] ? ~ext_joy_data[p] : shift_reg[0];
  end

  // Physical pads see the CPU's latch and clocks directly.
  assign ext_joy_latch = joy_strobe;
  assign ext_joy_clock = joy_clock;

  // -------------------------------------------------------------------------
  // Change detection: raw button latch and settle counter
  // -------------------------------------------------------------------------
  logic [8*C_ports-1:0] btn_latch;
  logic [DB_W-1:0]      deb_cnt;
  logic                 deb_settled;
  logic                 report;

  // The counter stops once its MSB sets. That MSB marks "settled".
  assign deb_settled = deb_cnt[DB_W-1];

  // An acknowledge in the same cycle blocks a new report. The pending change
  // is then picked up on a later cycle.
  assign report = (btn_latch != o_btn) && deb_settled && !o_irq && !i_irq_ack;

  // The raw buttons are latched without autofire gating, so a held
  // autofire button does not keep raising interrupts.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_latch <= '0;
    end else begin
      btn_latch <= i_buttons;
    end
  end

  // The settle window restarts at every report. This rate-limits interrupts
  // to one per 2^(C_debounce_bits-1) cycles at most.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_cnt <= '0;
    end else if (report) begin
      deb_cnt <= '0;
    end else if (!deb_settled) begin
      deb_cnt <= deb_cnt + DB_ONE;
    end
  end

  // o_btn is frozen while o_irq is high. Software always reads a state that
  // matches the interrupt it is servicing.
  always_ff @(posedge clock) begin
    if (reset) begin
      o_btn <= '0;
      o_irq <= 1'b0;
    end else if (report) begin
      o_btn <= btn_latch;
      o_irq <= 1'b1;
    end else if (i_irq_ack) begin
      o_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nes_joypad_ports.sv
// ---------------------------------------------------------------------------
// tb_nes_joypad_ports
//
// Testbench for nes_joypad_ports. It runs with small autofire and debounce
// parameters so that scenarios stay short. A behavioural model follows each
// port as "loaded byte + number of reads so far". It tracks autofire as a
// function of cycles since reset, and interrupts as "cycles since the last
// report". Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_nes_joypad_ports;

  localparam int PORTS    = 2;
  localparam int AF_DIV   = 4;
  localparam int DEB_BITS = 4;
  localparam int FILL     = 1;
  localparam int SETTLE   = 1 << (DEB_BITS - 1);

  logic                 clock = 1'b0;
  logic                 reset;
  logic [8*PORTS-1:0]   i_buttons;
  logic [8*PORTS-1:0]   i_autofire_mask;
  logic [PORTS-1:0]     i_ext_select;
  logic                 joy_strobe;
  logic [PORTS-1:0]     joy_clock;
  logic [PORTS-1:0]     o_joy_data;
  logic [PORTS-1:0]     ext_joy_data;
  logic                 ext_joy_latch;
  logic [PORTS-1:0]     ext_joy_clock;
  logic [8*PORTS-1:0]   o_btn;
  logic                 o_irq;
  logic                 i_irq_ack;

  int checks = 0;
  int errors = 0;

  // Model state
  int                 edges;
  logic [7:0]         m_loaded [PORTS];
  int                 m_reads  [PORTS];
  logic [PORTS-1:0]   m_prev_clk;
  logic [8*PORTS-1:0] m_latch;
  logic [8*PORTS-1:0] m_btn;
  logic               m_irq;
  int                 m_settle;

  nes_joypad_ports #(
    .C_ports         (PORTS),
    .C_autofire_div  (AF_DIV),
    .C_debounce_bits (DEB_BITS),
    .C_fill_ones     (FILL)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .i_buttons       (i_buttons),
    .i_autofire_mask (i_autofire_mask),
    .i_ext_select    (i_ext_select),
    .joy_strobe      (joy_strobe),
    .joy_clock       (joy_clock),
    .o_joy_data      (o_joy_data),
    .ext_joy_data    (ext_joy_data),
    .ext_joy_latch   (ext_joy_latch),
    .ext_joy_clock   (ext_joy_clock),
    .o_btn           (o_btn),
    .o_irq           (o_irq),
    .i_irq_ack       (i_irq_ack)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Advance the model by one clock edge, using the inputs the DUT is about
  // to sample.
  task automatic modelEdge();
    logic       phase;
    logic [7:0] eff;
    logic       do_report;
    if (reset) begin
      edges = 0;
      for (int p = 0; p < PORTS; p++) begin
        m_loaded[p] = 8'h00;
        m_reads[p]  = 0;
      end
      m_prev_clk = '0;
      m_latch    = '0;
      m_btn      = '0;
      m_irq      = 1'b0;
      m_settle   = 0;
    end else begin
      phase = ((edges / AF_DIV) % 2) == 1;
      for (int p = 0; p < PORTS; p++) begin
        if (joy_strobe) begin
          eff = i_buttons[8*p +: 8] & (~i_autofire_mask[8*p +: 8] | {8{phase}});
          m_loaded[p] = eff;
          m_reads[p]  = 0;
        end else if (m_prev_clk[p] && !joy_clock[p]) begin
          m_reads[p]++;
        end
      end
      m_prev_clk = joy_clock;
      do_report = !i_irq_ack && (m_settle >= SETTLE) && (m_latch != m_btn) && !m_irq;
      if (i_irq_ack) m_irq = 1'b0;
      if (do_report) begin
        m_btn    = m_latch;
        m_irq    = 1'b1;
        m_settle = 0;
      end else if (m_settle < SETTLE) begin
        m_settle++;
      end
      m_latch = i_buttons;
      edges++;
    end
  endtask

  task automatic compareAll();
    logic [PORTS-1:0] exp_data;
    logic [7:0]       b;
    for (int p = 0; p < PORTS; p++) begin
      b = m_loaded[p];
      if (i_ext_select[p]) exp_data[p] = ~ext_joy_data[p];
      else if (m_reads[p] < 8) exp_data[p] = b[m_reads[p]];
      else exp_data[p] = (FILL != 0);
    end
    checkOutput("joy_data", 32'(o_joy_data), 32'(exp_data));
    checkOutput("btn", 32'(o_btn), 32'(m_btn));
    checkOutput("irq", 32'(o_irq), 32'(m_irq));
    checkOutput("ext_latch", 32'(ext_joy_latch), 32'(joy_strobe));
    checkOutput("ext_clock", 32'(ext_joy_clock), 32'(joy_clock));
  endtask

  // One clock cycle with the currently driven inputs, checked afterwards.
  task automatic applyStimulus();
    modelEdge();
    @(posedge clock);
    #1;
    compareAll();
  endtask

  task automatic readEdge(input int p);
    joy_clock[p] = 1'b1;
    applyStimulus();
    joy_clock[p] = 1'b0;
    applyStimulus();
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    i_buttons       = '0;
    i_autofire_mask = '0;
    i_ext_select    = '0;
    joy_strobe      = 1'b0;
    joy_clock       = '0;
    ext_joy_data    = '1;
    i_irq_ack       = 1'b0;

    // Reset state
    doReset();
    checkOutput("rst_data", 32'(o_joy_data), 32'h0);
    checkOutput("rst_btn", 32'(o_btn), 32'h0);
    checkOutput("rst_irq", 32'(o_irq), 32'h0);

    // Internal readout of 0x81 followed by fill bits
    i_buttons = 16'h0081;
    joy_strobe = 1'b1;
    applyStimulus();
    joy_strobe = 1'b0;
    applyStimulus();
    for (int i = 0; i < 10; i++) begin
      checkOutput("read81", 32'(o_joy_data[0]), (i == 0 || i >= 7) ? 32'h1 : 32'h0);
      readEdge(0);
    end

    // Strobe coincident with a falling edge: load wins, no shift
    i_buttons = 16'h0002;
    joy_clock[0] = 1'b1;
    applyStimulus();
    joy_strobe = 1'b1;
    joy_clock[0] = 1'b0;
    applyStimulus();
    checkOutput("strobe_edge_bit0", 32'(o_joy_data[0]), 32'h0);
    joy_strobe = 1'b0;
    applyStimulus();
    checkOutput("strobe_edge_hold", 32'(o_joy_data[0]), 32'h0);
    readEdge(0);
    checkOutput("strobe_edge_bit1", 32'(o_joy_data[0]), 32'h1);

    // Autofire: port0 A masked, port1 A unmasked, strobe held
    i_buttons       = 16'h0103;
    i_autofire_mask = 16'h0001;
    joy_strobe      = 1'b1;
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      checkOutput("af_masked", 32'(o_joy_data[0]), 32'((i / AF_DIV) % 2));
      checkOutput("af_unmasked", 32'(o_joy_data[1]), 32'h1);
    end
    joy_strobe = 1'b0;
    applyStimulus();
    readEdge(0);
    checkOutput("af_b_unmasked", 32'(o_joy_data[0]), 32'h1);
    i_autofire_mask = '0;

    // External pad on port 1 (combinational paths)
    i_ext_select = 2'b10;
    ext_joy_data = 2'b01;
    #1;
    checkOutput("ext_pressed", 32'(o_joy_data[1]), 32'h1);
    joy_clock[1] = 1'b1;
    #1;
    checkOutput("ext_clk_hi", 32'(ext_joy_clock[1]), 32'h1);
    ext_joy_data[1] = 1'b1;
    #1;
    checkOutput("ext_released", 32'(o_joy_data[1]), 32'h0);
    applyStimulus();
    joy_clock[1] = 1'b0;
    #1;
    checkOutput("ext_clk_lo", 32'(ext_joy_clock[1]), 32'h0);
    applyStimulus();
    i_ext_select = 2'b00;
    #1;
    compareAll();

    // Interrupt debounce
    i_buttons = '0;
    doReset();
    i_buttons = 16'h0010;
    for (int i = 1; i <= 8; i++) applyStimulus();
    checkOutput("irq_before_settle", 32'(o_irq), 32'h0);
    applyStimulus();
    checkOutput("irq_set", 32'(o_irq), 32'h1);
    checkOutput("irq_btn", 32'(o_btn), 32'h0010);
    i_buttons = 16'h0000;
    for (int i = 0; i < 12; i++) applyStimulus();
    checkOutput("irq_btn_frozen", 32'(o_btn), 32'h0010);
    i_irq_ack = 1'b1;
    applyStimulus();
    checkOutput("irq_acked", 32'(o_irq), 32'h0);
    i_irq_ack = 1'b0;
    applyStimulus();
    checkOutput("irq_reupdate", 32'(o_irq), 32'h1);
    checkOutput("irq_reupdate_btn", 32'(o_btn), 32'h0000);
    i_irq_ack = 1'b1;
    applyStimulus();
    i_irq_ack = 1'b0;

    // Reset in the middle of a read
    i_buttons = 16'h00AD;
    joy_strobe = 1'b1;
    applyStimulus();
    joy_strobe = 1'b0;
    for (int i = 0; i < 3; i++) readEdge(0);
    checkOutput("mid_read_bit3", 32'(o_joy_data[0]), 32'h1);
    reset = 1'b1;
    applyStimulus();
    checkOutput("mid_rst_data", 32'(o_joy_data[0]), 32'h0);
    checkOutput("mid_rst_irq", 32'(o_irq), 32'h0);
    reset = 1'b0;
    joy_strobe = 1'b1;
    applyStimulus();
    joy_strobe = 1'b0;
    checkOutput("reload_bit0", 32'(o_joy_data[0]), 32'h1);
    readEdge(0);
    checkOutput("reload_bit1", 32'(o_joy_data[0]), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      joy_strobe = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < PORTS; p++) begin
        if ($urandom_range(0, 2) == 0) joy_clock[p] = ~joy_clock[p];
        if ($urandom_range(0, 49) == 0) i_ext_select[p] = ~i_ext_select[p];
      end
      if ($urandom_range(0, 19) == 0) i_buttons = 16'($urandom);
      if ($urandom_range(0, 99) == 0) i_autofire_mask = 16'($urandom);
      ext_joy_data = PORTS'($urandom);
      i_irq_ack    = ($urandom_range(0, 7) == 0);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
